// File: rtl/arm_pkg.sv
// Shared encodings for the ARM instruction encoder: class codes, ALUControl-to-cmd map,
// FSM state codes and instruction field positions.
package arm_pkg;

   localparam logic [1:0] CLS_DP  = 2'b00;
   localparam logic [1:0] CLS_MEM = 2'b01;
   localparam logic [1:0] CLS_BR  = 2'b10;
   localparam logic [1:0] CLS_ILL = 2'b11;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_ORR = 3'b011;
   localparam logic [2:0] ALU_EOR = 3'b110;

   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_EOR = 4'b0001;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE   = 2'd0;
   localparam state_t ST_ACCEPT = 2'd1;
   localparam state_t ST_WRITE  = 2'd2;
   localparam state_t ST_FINISH = 2'd3;

   localparam int COND_MSB  = 31;
   localparam int COND_LSB  = 28;
   localparam int OP_MSB    = 27;
   localparam int OP_LSB    = 26;
   localparam int I_BIT     = 25;
   localparam int CMD_MSB   = 24;
   localparam int CMD_LSB   = 21;
   localparam int S_BIT     = 20;
   localparam int P_BIT     = 24;
   localparam int U_BIT     = 23;
   localparam int B_BIT     = 22;
   localparam int W_BIT     = 21;
   localparam int L_BIT     = 20;
   localparam int BR_L_BIT  = 24;
   localparam int RN_MSB    = 19;
   localparam int RN_LSB    = 16;
   localparam int RD_MSB    = 15;
   localparam int RD_LSB    = 12;
   localparam int SRC2_MSB  = 11;
   localparam int IMM24_MSB = 23;

   typedef struct packed {
      logic       legal;
      logic [3:0] cmd;
   } alu_map_t;

   function automatic alu_map_t alu_to_cmd(input logic [2:0] op);
      alu_map_t m;
      m.legal = 1'b1;
      m.cmd   = CMD_AND;
      case (op)
         ALU_ADD: m.cmd = CMD_ADD;
         ALU_SUB: m.cmd = CMD_SUB;
         ALU_AND: m.cmd = CMD_AND;
         ALU_ORR: m.cmd = CMD_ORR;
         ALU_EOR: m.cmd = CMD_EOR;
         default: m.legal = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/arm_field_pack.sv
// Combinational packer: decoded instruction fields -> 32-bit ARM word, plus a legal flag.
// Zero latency; no handshake of its own.
module arm_field_pack
   import arm_pkg::*;
(
   input  logic [1:0]  cls,
   input  logic [3:0]  cond,
   input  logic [2:0]  alu_op,
   input  logic        s,
   input  logic        imm,
   input  logic        load,
   input  logic        byte_sel,
   input  logic [3:0]  rn,
   input  logic [3:0]  rd,
   input  logic [11:0] src2,
   input  logic [23:0] imm24,
   output logic [31:0] word,
   output logic        legal
);

   alu_map_t dp_map;
   assign dp_map = alu_to_cmd(alu_op);

   always_comb begin
      word  = '0;
      legal = 1'b0;
      word[COND_MSB:COND_LSB] = cond;
      case (cls)
         CLS_DP: begin
            word[OP_MSB:OP_LSB]   = OP_DP;
            word[I_BIT]           = imm;
            word[CMD_MSB:CMD_LSB] = dp_map.cmd;
            word[S_BIT]           = s;
            word[RN_MSB:RN_LSB]   = rn;
            word[RD_MSB:RD_LSB]   = rd;
            word[SRC2_MSB:0]      = src2;
            legal                 = dp_map.legal;
         end
         CLS_MEM: begin
            // Memory form inverts the immediate sense: I=0 means a 12-bit offset.
            word[OP_MSB:OP_LSB] = OP_MEM;
            word[I_BIT]         = ~imm;
            word[P_BIT]         = 1'b1;
            word[U_BIT]         = 1'b1;
            word[B_BIT]         = byte_sel;
            word[W_BIT]         = 1'b0;
            word[L_BIT]         = load;
            word[RN_MSB:RN_LSB] = rn;
            word[RD_MSB:RD_LSB] = rd;
            word[SRC2_MSB:0]    = src2;
            legal               = 1'b1;
         end
         CLS_BR: begin
            word[OP_MSB:OP_LSB] = OP_BR;
            word[I_BIT]         = 1'b1;
            word[BR_L_BIT]      = 1'b0;
            word[IMM24_MSB:0]   = imm24;
            legal               = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/arm_instr_encoder.sv
// Program loader: encodes requests and writes them to consecutive imem words; accept->write 1 cycle, 1 word/2 cycles.
// in_ready only in ACCEPT. ARM_ENC_CHECKSUM_EN adds an XOR checksum of written words.
module arm_instr_encoder
   import arm_pkg::*;
#(
   parameter int                 ADDR_W    = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
   parameter int                 DEPTH     = 64
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        in_last,
   input  logic [1:0]                  in_class,
   input  logic [3:0]                  in_cond,
   input  logic [2:0]                  in_alu_op,
   input  logic                        in_s,
   input  logic                        in_imm,
   input  logic                        in_load,
   input  logic                        in_byte,
   input  logic [3:0]                  in_rn,
   input  logic [3:0]                  in_rd,
   input  logic [11:0]                 in_src2,
   input  logic [23:0]                 in_imm24,
   output logic                        imem_we,
   output logic [ADDR_W-1:0]           imem_addr,
   output logic [31:0]                 imem_wd,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [$clog2(DEPTH+1)-1:0]  count
`ifdef ARM_ENC_CHECKSUM_EN
   ,
   output logic [31:0]                 checksum
`endif
);

   localparam int CNT_W = $clog2(DEPTH+1);

   state_t             state;
   logic [31:0]        enc_word;
   logic               enc_legal;
   logic               last_q;
   logic [CNT_W-1:0]   count_inc;
   logic               full;

   arm_field_pack u_pack (
      .cls      (in_class),
      .cond     (in_cond),
      .alu_op   (in_alu_op),
      .s        (in_s),
      .imm      (in_imm),
      .load     (in_load),
      .byte_sel (in_byte),
      .rn       (in_rn),
      .rd       (in_rd),
      .src2     (in_src2),
      .imm24    (in_imm24),
      .word     (enc_word),
      .legal    (enc_legal)
   );

   assign in_ready  = (state == ST_ACCEPT);
   assign imem_we   = (state == ST_WRITE);
   assign busy      = (state == ST_ACCEPT) || (state == ST_WRITE);
   assign done      = (state == ST_FINISH);
   assign count_inc = count + CNT_W'(1);
   assign full      = (count_inc == CNT_W'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         imem_addr <= BASE_ADDR;
         imem_wd   <= '0;
         count     <= '0;
         err       <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_ACCEPT;
                  err       <= 1'b0;
                  count     <= '0;
                  imem_addr <= BASE_ADDR;
               end
            end
            ST_ACCEPT: begin
               if (in_valid) begin
                  if (enc_legal) begin
                     imem_wd <= enc_word;
                     last_q  <= in_last;
                     state   <= ST_WRITE;
                  end else begin
                     // Illegal words are dropped; the address is not consumed.
                     err <= 1'b1;
                     if (in_last) state <= ST_FINISH;
                  end
               end
            end
            ST_WRITE: begin
               count     <= count_inc;
               imem_addr <= imem_addr + ADDR_W'(4);
               if (last_q || full) state <= ST_FINISH;
               else                state <= ST_ACCEPT;
               if (full && !last_q) err <= 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef ARM_ENC_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             checksum <= '0;
      else if (state == ST_IDLE && start)    checksum <= '0;
      else if (state == ST_WRITE)            checksum <= checksum ^ imem_wd;
   end
`endif

endmodule

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
- Sequential program loader: accepts decoded-field instruction requests over a valid/ready handshake and encodes each into a 32-bit ARM word (DP, LDR/STR/LDRB/STRB, B).
- Writes the words to instruction memory at consecutive word addresses.
- It is the writer/encoder counterpart of the core's main/ALU instruction decoder. It fills imem before the core is released from reset, for self-loading testbenches and boot.

Parameters:
- ADDR_W, 32, imem address width.
- BASE_ADDR, 0, byte address of the first word written.
- DEPTH, 64, maximum number of words per load session.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load session at BASE_ADDR
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- in_last  in  1  marks the final request of a session
- in_class  in  2  00 DP, 01 MEM, 10 BR, 11 illegal
- in_cond  in  4  condition field
- in_alu_op  in  3  ALUControl code: 000 ADD, 001 SUB, 010 AND, 011 ORR, 110 EOR; others illegal
- in_s  in  1  set-flags bit (DP only)
- in_imm  in  1  src2 is immediate
- in_load  in  1  MEM: 1 LDR, 0 STR
- in_byte  in  1  MEM: byte access (B bit)
- in_rn  in  4  Rn
- in_rd  in  4  Rd
- in_src2  in  12  immediate/shifted-register field
- in_imm24  in  24  branch offset
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  byte address
- imem_wd  out  32  encoded word
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- err  out  1  sticky error, cleared by start
- count  out  $clog2(DEPTH+1)  words written this session

Behaviour:
- Reset: all outputs 0; imem_addr = BASE_ADDR; FSM in IDLE.
- Reset mid-session aborts the session with no further writes.
- FSM states: IDLE, ACCEPT, WRITE, FINISH.
- IDLE: start -> ACCEPT, clear err and count, set addr = BASE_ADDR, busy = 1. Requests are ignored in IDLE.
- ACCEPT: in_ready = 1. On in_valid & in_ready, capture and encode into a register.
  - Legal request -> WRITE.
  - Illegal request (class 11, or DP with alu_op not in the legal set) -> set err and drop the word. Go to FINISH if in_last, else stay in ACCEPT.
- WRITE: imem_we = 1 for exactly one cycle with the registered addr/wd. Then count += 1 and addr += 4.
  - If the captured in_last, or the new count == DEPTH -> FINISH. Else -> ACCEPT.
- FINISH: done = 1 for one cycle, busy = 0, then IDLE.
- Overflow: reaching count == DEPTH without in_last also sets err.
- start while busy is ignored.
- Latency: accept at cycle N -> imem_we at N+1. Throughput is 1 word per 2 cycles. in_ready = 0 in all states except ACCEPT.
- DP encoding: cond | 00 | I | cmd | S | Rn | Rd | src2. cmd: ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001.
- MEM encoding: cond | 01 | ~I | P=1 | U=1 | B | W=0 | L | Rn | Rd | src2.
- BR encoding: cond | 10 | 1 | 0 | imm24.
- Rd = 15 is legal (PC write); no special handling.
- Address wrap at 2^ADDR_W is not checked.

Optional Feature:
- ARM_ENC_CHECKSUM_EN: adds output checksum [31:0].
  - checksum is cleared on start, and XOR-accumulates every word actually written (on imem_we).
- Without the macro, the port and logic are absent.

Decomposition:
- Shared package arm_pkg:
  - class codes;
  - ALUControl codes and their cmd mapping;
  - FSM state typedef;
  - field position constants (COND_MSB, OP_LSB, etc.).
- Sub-module arm_field_pack: combinational field-to-word encoder with a legal flag. The FSM, counter and handshake live in the top module.

Test Plan:
- ADD R2,R0,#5, cond E (class 00, alu 000, imm 1, src2 0x005) -> imem_we at addr BASE, wd = 0xE2802005.
- SUBS R1,R1,R2 (alu 001, s 1, imm 0, src2 0x002) -> wd = 0xE0511002.
- LDR R3,[R0,#8] then STRB R3,[R0,#4] (imm 1), last on the second request -> 0xE5903008 @ BASE, 0xE5C03004 @ BASE+4, done pulse, count = 2.
- B with imm24 = 0xFFFFFE, cond E, last -> wd = 0xEAFFFFFE, done one cycle, busy falls.
- Illegal alu_op 100 mid-stream -> no write, err = 1, next legal word goes to the unchanged address. A new start clears err.
- DEPTH = 2, three requests without last -> two writes, err = 1, done, third request never gets in_ready. Reset asserted between accept and WRITE -> no imem_we, outputs 0.
